// File: rtl/cam_pkg.sv
// cam_pkg: pixel format, transmitter FSM states and default frame geometry
// shared by cam_tx and mem_controller.
package cam_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;

  // RGB444 pixel, packed as {R,G,B} to match the 12-bit source bus.
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef enum logic [2:0] {
    IDLE,
    VSYNC,
    VBP,
    HBLANK,
    ACTIVE
  } state_t;

endpackage

// File: rtl/cam_tx_pclk_gen.sv
// cam_tx_pclk_gen: free-running pixel clock divider. pclk is low for the
// first half of each PCLK_DIV period and high for the second half. The rise
// and fall strobes are high in the sys_clk cycle whose closing edge toggles
// pclk, so logic clocked on that edge updates together with pclk.
module cam_tx_pclk_gen #(
  parameter int PCLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic pclk,
  output logic rise,
  output logic fall
);

  localparam logic [15:0] RISE_AT = 16'(PCLK_DIV / 2 - 1);
  localparam logic [15:0] FALL_AT = 16'(PCLK_DIV - 1);

  logic [15:0] cnt;

  assign rise = (cnt == RISE_AT);
  assign fall = (cnt == FALL_AT);

  // Divider counter and registered pclk level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      pclk <= 1'b0;
    end else begin
      cnt <= fall ? '0 : cnt + 16'd1;
      if (rise) begin
        pclk <= 1'b1;
      end else if (fall) begin
        pclk <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cam_tx.sv
// cam_tx: camera-style DVP transmitter emitting RGB444 frames as two bytes
// per pixel with vsync/href framing. All framing outputs change on the
// sys_clk edge where pclk falls.
// Build option: define CAM_TX_PATTERN_EN to replace the external pixel
// stream with a per-frame running pixel count (pix_rd then stays 0).
module cam_tx
  import cam_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int PCLK_DIV   = 4,
  parameter int VSYNC_LEN  = 3,
  parameter int VBP_LEN    = 17,
  parameter int HBLANK_LEN = 144
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        start,
  input  logic        cont,
  input  logic        pix_valid,
  input  logic [11:0] pix_data,
  output logic        pix_rd,
  output logic        pclk,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  data,
  output logic        busy,
  output logic        done,
  output logic        underrun
);

  localparam logic [15:0] VSYNC_LAST  = 16'(VSYNC_LEN - 1);
  localparam logic [15:0] VBP_LAST    = 16'(VBP_LEN - 1);
  localparam logic [15:0] HBLANK_LAST = 16'(HBLANK_LEN - 1);
  localparam logic [15:0] COL_LAST    = 16'(H_ACTIVE - 1);
  localparam logic [15:0] ROW_LAST    = 16'(V_ACTIVE - 1);

  state_t      state;
  logic        pending;
  logic [15:0] tcnt;
  logic [15:0] col;
  logic [15:0] row;
  logic        byte_sel;
  rgb444_t     pix_q;
  rgb444_t     src_pix;
  logic        src_ok;
  logic        rd_en;
  logic        pclk_rise;
  logic        pclk_fall;
  logic        start_ok;
  logic        frame_end;
  logic        frame_start;
  logic        emit0;
  logic        unused_rise;

  cam_tx_pclk_gen #(
    .PCLK_DIV(PCLK_DIV)
  ) u_pclk_gen (
    .clk  (sys_clk),
    .rst_n(rst),
    .pclk (pclk),
    .rise (pclk_rise),
    .fall (pclk_fall)
  );

  assign unused_rise = pclk_rise;

`ifdef CAM_TX_PATTERN_EN
  logic [11:0] pat;
  logic        unused_src;

  assign unused_src = ^{pix_valid, pix_data};

  // Pattern source: running pixel count that restarts on every frame.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      pat <= '0;
    end else if (frame_start) begin
      pat <= '0;
    end else if (emit0) begin
      pat <= pat + 12'd1;
    end
  end

  // Pattern pixels are always available and never consumed from outside.
  always_comb begin
    src_pix = rgb444_t'(pat);
    src_ok  = 1'b1;
    rd_en   = 1'b0;
  end
`else
  // External FWFT source; a missing pixel is replaced by black.
  always_comb begin
    src_pix = pix_valid ? rgb444_t'(pix_data) : '0;
    src_ok  = pix_valid;
    rd_en   = pix_valid;
  end
`endif

  // Frame boundaries and byte-0 emission points, all qualified by pclk fall.
  always_comb begin
    start_ok    = start && !busy;
    frame_end   = pclk_fall && (state == ACTIVE) && byte_sel &&
                  (col == COL_LAST) && (row == ROW_LAST);
    frame_start = (pclk_fall && (state == IDLE) && (pending || start_ok)) ||
                  (frame_end && cont);
    emit0       = pclk_fall &&
                  (((state == HBLANK) && (tcnt == HBLANK_LAST)) ||
                   ((state == ACTIVE) && byte_sel && (col != COL_LAST)));
  end

  // Frame FSM; frame entry and byte-0 emission override the per-state
  // updates so a line/frame start shares one code path with mid-line pixels.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      vsync    <= 1'b0;
      href     <= 1'b0;
      data     <= '0;
      pix_rd   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      underrun <= 1'b0;
      pending  <= 1'b0;
      tcnt     <= '0;
      col      <= '0;
      row      <= '0;
      byte_sel <= 1'b0;
      pix_q    <= '0;
    end else begin
      pix_rd <= 1'b0;
      done   <= 1'b0;
      if (start_ok) begin
        pending  <= 1'b1;
        underrun <= 1'b0;
      end
      if (pclk_fall) begin
        pending <= 1'b0;
        unique case (state)
          IDLE: ;
          VSYNC: begin
            if (tcnt == VSYNC_LAST) begin
              state <= VBP;
              vsync <= 1'b0;
              tcnt  <= '0;
            end else begin
              tcnt <= tcnt + 16'd1;
            end
          end
          VBP: begin
            if (tcnt == VBP_LAST) begin
              state <= HBLANK;
              tcnt  <= '0;
            end else begin
              tcnt <= tcnt + 16'd1;
            end
          end
          HBLANK: begin
            if (tcnt == HBLANK_LAST) begin
              state <= ACTIVE;
              href  <= 1'b1;
              tcnt  <= '0;
            end else begin
              tcnt <= tcnt + 16'd1;
            end
          end
          ACTIVE: begin
            if (!byte_sel) begin
              data     <= {pix_q.g, pix_q.b};
              byte_sel <= 1'b1;
            end else if (col == COL_LAST) begin
              col      <= '0;
              byte_sel <= 1'b0;
              href     <= 1'b0;
              data     <= '0;
              if (row == ROW_LAST) begin
                row  <= '0;
                done <= 1'b1;
                if (!cont) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                end
              end else begin
                row   <= row + 16'd1;
                state <= HBLANK;
              end
            end else begin
              col <= col + 16'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
      if (frame_start) begin
        state <= VSYNC;
        vsync <= 1'b1;
        busy  <= 1'b1;
        tcnt  <= '0;
      end
      if (emit0) begin
        pix_q    <= src_pix;
        data     <= {4'b0000, src_pix.r};
        byte_sel <= 1'b0;
        pix_rd   <= rd_en;
        if (!src_ok) begin
          underrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cam_tx.sv
// tb_cam_tx: scoreboard bench for cam_tx with a small 4x2 frame.
module tb_cam_tx;

  localparam int H    = 4;
  localparam int V    = 2;
  localparam int DIV  = 4;
  localparam int VSL  = 2;
  localparam int VBPL = 3;
  localparam int HBL  = 2;
  localparam int NPIX = H * V;
  localparam int NBYT = 2 * NPIX;

  logic        sys_clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        cont = 1'b0;
  logic        pix_valid = 1'b0;
  logic [11:0] pix_data = '0;
  logic        pix_rd;
  logic        pclk;
  logic        vsync;
  logic        href;
  logic [7:0]  data;
  logic        busy;
  logic        done;
  logic        underrun;

  cam_tx #(
    .H_ACTIVE  (H),
    .V_ACTIVE  (V),
    .PCLK_DIV  (DIV),
    .VSYNC_LEN (VSL),
    .VBP_LEN   (VBPL),
    .HBLANK_LEN(HBL)
  ) dut (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .start    (start),
    .cont     (cont),
    .pix_valid(pix_valid),
    .pix_data (pix_data),
    .pix_rd   (pix_rd),
    .pclk     (pclk),
    .vsync    (vsync),
    .href     (href),
    .data     (data),
    .busy     (busy),
    .done     (done),
    .underrun (underrun)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int failures = 0;

  logic [11:0] src_q[$];
  logic [7:0]  sb_q[$];
  logic        sb_en = 1'b0;
  int          drop_at = -1;

  int   mon_bytes = 0, pix_rd_cnt = 0, vsync_rises = 0, href_rises = 0;
  int   done_cnt = 0, viol = 0, meas = 0, meas_result = -1, busy_until = 0;
  logic meas_on = 1'b0, track_busy = 1'b0, busy_drop = 1'b0;
  logic prev_pclk = 1'b0, prev_vsync = 1'b0, prev_href = 1'b0, prev_rst = 1'b0;
  logic [7:0] prev_data = '0;
  logic [7:0] exp_byte;

  logic [11:0] src_tab [NPIX] = '{12'h123, 12'h456, 12'h789, 12'hABC,
                                  12'hDEF, 12'h135, 12'h246, 12'h357};
`ifdef CAM_TX_PATTERN_EN
  localparam int EXP_RD = 0;
  logic [7:0] exp_tab [NBYT] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03,
                                 8'h00, 8'h04, 8'h00, 8'h05, 8'h00, 8'h06, 8'h00, 8'h07};
`else
  localparam int EXP_RD = NPIX;
  logic [7:0] exp_tab [NBYT] = '{8'h01, 8'h23, 8'h04, 8'h56, 8'h07, 8'h89, 8'h0A, 8'hBC,
                                 8'h0D, 8'hEF, 8'h01, 8'h35, 8'h02, 8'h46, 8'h03, 8'h57};
  // Pixel 2 dropped: black pixel, then the stream continues with 0x789.
  logic [7:0] exp_drop [NBYT] = '{8'h01, 8'h23, 8'h04, 8'h56, 8'h00, 8'h00, 8'h07, 8'h89,
                                  8'h0A, 8'hBC, 8'h0D, 8'hEF, 8'h01, 8'h35, 8'h02, 8'h46};
`endif

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Monitor: timing rules, scoreboard pops, event counters and the FWFT source.
  always @(negedge sys_clk) begin
    if (rst && prev_rst && ((data != prev_data) || (href != prev_href)) &&
        !(!pclk && prev_pclk)) begin
      viol++;
    end
    if (pclk && !prev_pclk) begin
      if (meas_on) meas++;
      if (href) begin
        mon_bytes++;
        if (sb_en) begin
          if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected_byte: actual=0x%0h required=no byte", data);
          end else begin
            exp_byte = sb_q.pop_front();
            check("sb_byte", int'(data), int'(exp_byte));
          end
        end
      end
    end
    if (pix_rd) begin
      pix_rd_cnt++;
      if (src_q.size() > 0) void'(src_q.pop_front());
    end
    if (vsync && !prev_vsync) begin
      vsync_rises++;
      meas_on = 1'b1;
      meas    = 0;
    end
    if (href && !prev_href) begin
      href_rises++;
      if (meas_on) begin
        meas_result = meas;
        meas_on     = 1'b0;
      end
    end
    if (done) done_cnt++;
    if (track_busy && !busy && (done_cnt < busy_until)) busy_drop = 1'b1;
    pix_valid  = (src_q.size() > 0) && !((drop_at >= 0) && (mon_bytes == 2 * drop_at));
    pix_data   = (src_q.size() > 0) ? src_q[0] : '0;
    prev_pclk  = pclk;
    prev_vsync = vsync;
    prev_href  = href;
    prev_data  = data;
    prev_rst   = rst;
  end

  task automatic clear_counters();
    mon_bytes   = 0;
    pix_rd_cnt  = 0;
    vsync_rises = 0;
    href_rises  = 0;
    done_cnt    = 0;
    meas_result = -1;
    busy_drop   = 1'b0;
  endtask

  task automatic load_src();
    for (int i = 0; i < NPIX; i++) src_q.push_back(src_tab[i]);
  endtask

  task automatic push_exp(input logic use_drop);
    for (int i = 0; i < NBYT; i++) begin
`ifdef CAM_TX_PATTERN_EN
      sb_q.push_back(exp_tab[i]);
      if (use_drop) $display("drop table unavailable in pattern build");
`else
      sb_q.push_back(use_drop ? exp_drop[i] : exp_tab[i]);
`endif
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int limit);
    int n = 0;
    while ((done_cnt < target) && (n < limit)) begin
      @(negedge sys_clk);
      n++;
    end
    if (done_cnt < target) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: actual=%0d done pulses required=%0d", done_cnt, target);
    end
  endtask

  task automatic wait_sig(input string name, input logic want_href, input int limit);
    int n = 0;
    while (((want_href ? href : busy) != 1'b1) && (n < limit)) begin
      @(negedge sys_clk);
      n++;
    end
    if ((want_href ? href : busy) != 1'b1) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: actual=0 required=1", name);
    end
  endtask

  function automatic int outs();
    return int'({pclk, vsync, href, data, pix_rd, busy, done, underrun});
  endfunction

  initial begin
    int snap;
    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("reset_outputs", outs(), 0);
    rst = 1'b1;
    @(negedge sys_clk);

    // Single frame
    clear_counters();
    load_src();
    push_exp(1'b0);
    sb_en = 1'b1;
    pulse_start();
    wait_done(1, 2000);
    check("f1_href_pulses", href_rises, V);
    check("f1_vsync_pulses", vsync_rises, 1);
    check("f1_pix_rd", pix_rd_cnt, EXP_RD);
    check("f1_underrun", int'(underrun), 0);
    check("f1_sb_left", sb_q.size(), 0);
    check("f1_busy_end", int'(busy), 0);
    repeat (40) @(negedge sys_clk);
    check("f1_done_once", done_cnt, 1);
    src_q.delete();

`ifndef CAM_TX_PATTERN_EN
    // Underrun on pixel 2
    clear_counters();
    load_src();
    drop_at = 2;
    push_exp(1'b1);
    pulse_start();
    wait_done(1, 2000);
    check("drop_underrun", int'(underrun), 1);
    check("drop_pix_rd", pix_rd_cnt, NPIX - 1);
    check("drop_sb_left", sb_q.size(), 0);
    drop_at = -1;
    src_q.delete();
    repeat (20) @(negedge sys_clk);
    check("underrun_sticky", int'(underrun), 1);
`endif

    // Two frames back to back, cont dropped during the second
    clear_counters();
    load_src();
    load_src();
    push_exp(1'b0);
    push_exp(1'b0);
    cont = 1'b1;
    pulse_start();
    wait_sig("busy", 1'b0, 100);
    busy_until = 2;
    track_busy = 1'b1;
    wait_done(1, 2000);
    cont = 1'b0;
    wait_done(2, 2000);
    track_busy = 1'b0;
    check("cont_vsync_pulses", vsync_rises, 2);
    check("cont_done_pulses", done_cnt, 2);
    check("cont_busy_gap", int'(busy_drop), 0);
    check("cont_underrun_cleared", int'(underrun), 0);
    check("cont_sb_left", sb_q.size(), 0);
    repeat (60) @(negedge sys_clk);
    check("cont_stops_busy", int'(busy), 0);
    check("cont_stops_done", done_cnt, 2);
    check("cont_stops_vsync", vsync_rises, 2);
    src_q.delete();

    // Reset in the middle of an active line
    clear_counters();
    load_src();
    sb_en = 1'b0;
    pulse_start();
    wait_sig("href", 1'b1, 2000);
    repeat (2) @(negedge sys_clk);
    rst = 1'b0;
    #1;
    check("rst_mid_outputs", outs(), 0);
    snap = pix_rd_cnt;
    repeat (10) @(negedge sys_clk);
    check("rst_no_pix_rd", pix_rd_cnt, snap);
    check("rst_hold_outputs", outs(), 0);
    rst = 1'b1;
    src_q.delete();
    sb_q.delete();
    @(negedge sys_clk);
    clear_counters();
    load_src();
    push_exp(1'b0);
    sb_en = 1'b1;
    pulse_start();
    wait_done(1, 2000);
    // vsync rise to first href rise spans VSYNC, VBP and the first line's HBLANK
    check("rst_vsync_to_href", meas_result, VSL + VBPL + HBL);
    check("rst_frame_sb_left", sb_q.size(), 0);
    check("rst_frame_pix_rd", pix_rd_cnt, EXP_RD);

    check("edge_violations", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
